// File: rtl/box_motion_ctrl_pkg.sv
// Shared constants for the box motion sequencer: screen defaults, colours and FSM encodings.
package box_motion_ctrl_pkg;

    localparam int X_MAX_DEF    = 160;
    localparam int Y_MAX_DEF    = 120;
    localparam int BOX_SIZE_DEF = 4;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ERASE_REQ  = 3'd1;
    localparam logic [2:0] S_ERASE_WAIT = 3'd2;
    localparam logic [2:0] S_MOVE       = 3'd3;
    localparam logic [2:0] S_DRAW_REQ   = 3'd4;
    localparam logic [2:0] S_DRAW_WAIT  = 3'd5;

    // Counter width for a 0..max-1 counter; a divide-by-1 still needs one bit.
    function automatic int cnt_width(input int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

// File: rtl/box_motion_ctrl_rate_divider.sv
// Free-running 0..MAX-1 counter advanced by enable; tick is high on the enabled wrap cycle.
module box_motion_ctrl_rate_divider
    import box_motion_ctrl_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int W = cnt_width(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (!reset)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-step sequencer for the box drawer: erase at the old position, bounce-move, draw at the new one.
module box_motion_ctrl
    import box_motion_ctrl_pkg::*;
#(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int FRAME_RATE      = 60,
    parameter int FRAMES_PER_STEP = 4,
    parameter int BOX_SIZE        = BOX_SIZE_DEF,
    parameter int X_MAX           = X_MAX_DEF,
    parameter int Y_MAX           = Y_MAX_DEF,
    parameter int X_INIT          = 0,
    parameter int Y_INIT          = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iEnable,
    input  logic [2:0] iColour,
    input  logic       iDone,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlotBox,
    output logic       oBusy
);

    localparam int TICKS = CLOCK_FREQ / FRAME_RATE;
    localparam logic [7:0] X_LAST = 8'(X_MAX - BOX_SIZE);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - BOX_SIZE);
    localparam logic [7:0] X_RST  = 8'(X_INIT);
    localparam logic [6:0] Y_RST  = 7'(Y_INIT);

    logic       frame_tick, step_tick;
    logic [2:0] state;
    logic [7:0] x;
    logic [6:0] y;
    logic       dx_neg, dy_neg;
    logic [2:0] colour_q;
    logic       wait_armed;

    box_motion_ctrl_rate_divider #(.MAX(TICKS)) u_frame_div (
        .clock (clock),
        .reset (reset),
        .enable(1'b1),
        .tick  (frame_tick)
    );

    box_motion_ctrl_rate_divider #(.MAX(FRAMES_PER_STEP)) u_step_div (
        .clock (clock),
        .reset (reset),
        .enable(frame_tick),
        .tick  (step_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            x          <= X_RST;
            y          <= Y_RST;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b0;
            colour_q   <= COLOUR_BLACK;
            wait_armed <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (step_tick && iEnable) state <= S_ERASE_REQ;
                S_ERASE_REQ: begin
                    wait_armed <= 1'b0;
                    state      <= S_ERASE_WAIT;
                end
                // The first WAIT cycle may still see done from the previous request.
                S_ERASE_WAIT:
                    if (!wait_armed)  wait_armed <= 1'b1;
                    else if (iDone)   state      <= S_MOVE;
                S_MOVE: begin
                    if (!dx_neg && x == X_LAST) begin
                        dx_neg <= 1'b1;
                        x      <= x - 8'd1;
                    end else if (dx_neg && x == 8'd0) begin
                        dx_neg <= 1'b0;
                        x      <= x + 8'd1;
                    end else begin
                        x <= dx_neg ? x - 8'd1 : x + 8'd1;
                    end
                    if (!dy_neg && y == Y_LAST) begin
                        dy_neg <= 1'b1;
                        y      <= y - 7'd1;
                    end else if (dy_neg && y == 7'd0) begin
                        dy_neg <= 1'b0;
                        y      <= y + 7'd1;
                    end else begin
                        y <= dy_neg ? y - 7'd1 : y + 7'd1;
                    end
                    colour_q <= iColour;
                    state    <= S_DRAW_REQ;
                end
                S_DRAW_REQ: begin
                    wait_armed <= 1'b0;
                    state      <= S_DRAW_WAIT;
                end
                S_DRAW_WAIT:
                    if (!wait_armed)  wait_armed <= 1'b1;
                    else if (iDone)   state      <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    assign oX       = x;
    assign oY       = y;
    assign oPlotBox = (state == S_ERASE_REQ) || (state == S_DRAW_REQ);
    assign oColour  = ((state == S_DRAW_REQ) || (state == S_DRAW_WAIT)) ? colour_q : COLOUR_BLACK;
    assign oBusy    = (state != S_IDLE);

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Scoreboard bench: three sequencers (plain, right-edge, corner start) driven together against a bounce model.
module tb_box_motion_ctrl;

    localparam int NI = 3;
    localparam int XL = 16 - 4;
    localparam int YL = 12 - 4;

    typedef struct {
        int x;
        int y;
        int c;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iEnable = 1'b0;
    logic [2:0] iColour = 3'd0;
    logic [7:0] ox [NI];
    logic [6:0] oy [NI];
    logic [2:0] oc [NI];
    logic       op [NI];
    logic       ob [NI];

    bit   done_hold = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q [NI][$];
    int   mx [NI], my [NI], mdx [NI], mdy [NI];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int init_x(input int i);
        return (i == 0) ? 0 : 12;
    endfunction

    function automatic int init_y(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 5 : 8);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic done_l = 1'b0;
        int   dcnt = 0;
        int   last = -100;
        exp_t e;

        box_motion_ctrl #(
            .CLOCK_FREQ(60), .FRAME_RATE(60), .FRAMES_PER_STEP(2), .BOX_SIZE(4),
            .X_MAX(16), .Y_MAX(12), .X_INIT(init_x(g)), .Y_INIT(init_y(g))
        ) dut (
            .clock   (clock),
            .reset   (reset),
            .iEnable (iEnable),
            .iColour (iColour),
            .iDone   (done_l),
            .oX      (ox[g]),
            .oY      (oy[g]),
            .oColour (oc[g]),
            .oPlotBox(op[g]),
            .oBusy   (ob[g])
        );

        // Drawer: done pulses three cycles after a request, or is stuck high in hold mode.
        always @(negedge clock) begin
            if (!reset) begin
                dcnt = 0;
                done_l = 1'b0;
            end else if (op[g]) begin
                dcnt = 3;
                done_l = done_hold;
            end else if (dcnt > 0) begin
                dcnt = dcnt - 1;
                done_l = done_hold || (dcnt == 0);
            end else begin
                done_l = done_hold;
            end
        end

        always @(negedge clock) begin
            if (!reset) begin
                last = -100;
            end else if (op[g]) begin
                total++;
                if (q[g].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse dut%0d got x=%0d y=%0d c=%0d, expected no pulse",
                             g, ox[g], oy[g], oc[g]);
                end else begin
                    e = q[g].pop_front();
                    if (ox[g] != e.x || oy[g] != e.y || oc[g] != e.c || !ob[g]) begin
                        bad++;
                        $display("FAIL pulse dut%0d got x=%0d y=%0d c=%0d busy=%0d, expected x=%0d y=%0d c=%0d busy=1",
                                 g, ox[g], oy[g], oc[g], ob[g], e.x, e.y, e.c);
                    end
                    if (last >= 0) begin
                        total++;
                        if ((cyc - last) < 4 || (done_hold && e.c != 0 && (cyc - last) != 4)) begin
                            bad++;
                            $display("FAIL pulse_gap dut%0d got %0d cycles, expected >=4 (==4 erase->draw with done held)",
                                     g, cyc - last);
                        end
                    end
                end
                last = cyc;
            end
        end
    end

    task automatic model_init();
        for (int i = 0; i < NI; i++) begin
            mx[i] = init_x(i);
            my[i] = init_y(i);
            mdx[i] = 1;
            mdy[i] = 1;
        end
    endtask

    task automatic push_step(input int col);
        exp_t t;
        for (int i = 0; i < NI; i++) begin
            t.x = mx[i]; t.y = my[i]; t.c = 0;
            q[i].push_back(t);
            if (mx[i] + mdx[i] > XL || mx[i] + mdx[i] < 0) mdx[i] = -mdx[i];
            if (my[i] + mdy[i] > YL || my[i] + mdy[i] < 0) mdy[i] = -mdy[i];
            mx[i] += mdx[i];
            my[i] += mdy[i];
            t.x = mx[i]; t.y = my[i]; t.c = col;
            q[i].push_back(t);
        end
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL %s got timeout, expected event within bound", what);
    endtask

    task automatic wait_rise(output bit ok);
        bit p;
        p = ob[0];
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ob[0] && !p) begin
                ok = 1'b1;
                break;
            end
            p = ob[0];
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80; k++) begin
            if (!ob[0]) return;
            @(negedge clock);
        end
        timeout("wait_idle");
    endtask

    task automatic run_batch(input int n, input int col, input bit hold);
        bit ok;
        wait_idle();
        done_hold = hold;
        iColour = 3'(col);
        iEnable = 1'b1;
        for (int k = 0; k < n; k++) push_step(col);
        for (int k = 0; k < n; k++) begin
            wait_rise(ok);
            if (!ok) timeout("busy_rise");
        end
        // Dropped inside the erase phase: the step must still run to its draw.
        iEnable = 1'b0;
        wait_idle();
        repeat ($urandom_range(0, 4)) @(negedge clock);
    endtask

    task automatic check_reset_state(input string what);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (ox[i] != init_x(i) || oy[i] != init_y(i) || op[i] || ob[i] || oc[i] != 3'd0) begin
                bad++;
                $display("FAIL %s dut%0d got x=%0d y=%0d plot=%0d busy=%0d c=%0d, expected x=%0d y=%0d plot=0 busy=0 c=0",
                         what, i, ox[i], oy[i], op[i], ob[i], oc[i], init_x(i), init_y(i));
            end
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        model_init();
        reset = 1'b1;

        run_batch(1, 5, 1'b0);
        for (int b = 0; b < 18; b++)
            run_batch($urandom_range(1, 3), $urandom_range(1, 7), b >= 12);

        // Reset arriving during DRAW_WAIT.
        wait_idle();
        done_hold = 1'b0;
        iColour = 3'd6;
        iEnable = 1'b1;
        push_step(6);
        wait_rise(ok);
        if (!ok) timeout("busy_rise_rst");
        iEnable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            seen = op[0] && oc[0] == 3'd6;
        end
        if (!seen) timeout("draw_pulse_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("mid_reset");
        reset = 1'b1;
        model_init();

        run_batch(2, 3, 1'b0);
        repeat (12) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (q[i].size() != 0) begin
                bad++;
                $display("FAIL leftover dut%0d got %0d pending pulses, expected 0", i, q[i].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
